uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver and next-generation replacement for the fixed 8N1 receive path behind uart_top.
- Configurable word length (5..MAX_DATA_BITS), parity mode and stop-bit count.
- Mid-bit sampling with an oversampling tick generator.
- Per-frame parity, framing and break status.
- Sits between the rx_data_i pin and the RX FIFO/register block; the config inputs are driven from UART_CFG / BAUD_CFG fields.

Parameters:
MAX_DATA_BITS, 9, largest supported word length (>=8)
OVERSAMPLE, 16, sample ticks per bit period (even, >=4)
DIV_WIDTH, 16, width of baud divisor

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
rx_data_i  in  1  asynchronous serial line, idle high
rx_en_i  in  1  receiver enable
baud_div_i  in  DIV_WIDTH  clocks per oversample tick
data_bits_i  in  4  word length, 5..MAX_DATA_BITS
parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 none
stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
rx_word_o  out  MAX_DATA_BITS  received word, LSB-aligned, unused MSBs zero
rx_valid_o  out  1  one-cycle pulse: frame complete
parity_err_o  out  1  parity mismatch for the frame in rx_word_o
frame_err_o  out  1  a stop bit sampled low
break_o  out  1  break detected
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (sync, active-high):
  - FSM goes to IDLE; all counters are cleared.
  - Synchronizer flops are set to 1.
  - All outputs are 0.
  - Reset mid-frame aborts the frame with no rx_valid_o pulse.
- Input sync: 2-flop synchronizer on rx_data_i. Falling-edge detect uses the synchronized value versus its previous value.
- Tick generator:
  - Counter runs 0..baud_div_i-1; a tick is issued on the cycle it wraps.
  - When baud_div_i==0 or rx_en_i==0, the counter is held at 0 and no ticks are issued.
  - Bit period = baud_div_i*OVERSAMPLE clocks.
- Config capture: data_bits_i, parity_mode_i and stop_bits_i are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Clamping: data_bits_i<5 is treated as 5; data_bits_i>MAX_DATA_BITS is treated as MAX_DATA_BITS.
- FSM states:
  - IDLE: on a falling edge with rx_en_i=1 -> START; clear the tick count.
  - START: on tick count OVERSAMPLE/2-1, sample the line. Low -> DATA with the tick count cleared. High -> IDLE (glitch reject; no pulse, no flags).
  - DATA: sample every OVERSAMPLE ticks (mid-bit), LSB first, into a shift register. After data_bits samples -> PARITY if parity is enabled, otherwise -> STOP.
  - PARITY: sample one bit. Even parity requires XOR(data,parity)=0; odd parity requires it =1. Latch the mismatch.
  - STOP: sample 1 or 2 stop bits. Any low sample sets the frame error.
    - After the last stop sample, one clock later: rx_word_o, parity_err_o, frame_err_o and break_o update, and rx_valid_o pulses for 1 cycle.
    - Then -> IDLE, or -> BRK_WAIT if a break was detected.
  - BRK_WAIT: stay until the synchronized line is high, then -> IDLE. No new start is accepted until then.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0. Asserts break_o=1 and frame_err_o=1. rx_word_o = 0.
- Output hold: rx_word_o and the flags hold until the next rx_valid_o. Flags always describe the word they accompany.
- rx_en_i deasserted in any non-IDLE state: next cycle -> IDLE with no pulse. Outputs are not modified.
- Back-to-back frames: a falling edge on the first IDLE cycle after STOP is accepted (no dead time beyond one clock).
- busy_o = 1 in START/DATA/PARITY/STOP/BRK_WAIT.

Test Plan:
1. baud_div=4, OVERSAMPLE=16 (64 clk/bit), 8N1, send 0xA5 -> one rx_valid_o pulse, rx_word_o=0x0A5, all flags 0, pulse within 10*64+8 clocks of the start edge.
2. 7E2, send 0x35 with correct parity, then 0x35 with a flipped parity bit -> first frame parity_err_o=0; second frame parity_err_o=1, rx_word_o=0x035.
3. 8N1, send 0x3C with the stop bit driven low -> rx_valid_o=1, frame_err_o=1, rx_word_o=0x03C. Then line held low for 12 bit periods -> break_o=1, rx_word_o=0, busy_o stays 1 until the line returns high, then the next 0x5A is received correctly.
4. Low glitch of 20 clocks (< half-bit of 32) -> no rx_valid_o; busy_o returns to 0; next frame 0x81 is received correctly.
5. Reset mid-DATA of 0xFF, then rx_en_i drop mid-frame on the following frame -> no pulse in either case, outputs 0 after reset, busy_o=0 one cycle after the drop.
6. 9-bit word 0x1F3, odd parity, followed back-to-back by 5-bit 0x15 (data_bits_i=3, clamped to 5) -> rx_word_o=0x1F3 then 0x015, no errors.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with parity, framing and break status
module uart_rx_cfg #(
   parameter int MAX_DATA_BITS = 9,
   parameter int OVERSAMPLE    = 16,
   parameter int DIV_WIDTH     = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     rx_data_i,
   input  logic                     rx_en_i,
   input  logic [DIV_WIDTH-1:0]     baud_div_i,
   input  logic [3:0]               data_bits_i,
   input  logic [1:0]               parity_mode_i,
   input  logic                     stop_bits_i,
   output logic [MAX_DATA_BITS-1:0] rx_word_o,
   output logic                     rx_valid_o,
   output logic                     parity_err_o,
   output logic                     frame_err_o,
   output logic                     break_o,
   output logic                     busy_o
);
   localparam int            TW        = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
   localparam logic [3:0]    MAX_BITS  = 4'(MAX_DATA_BITS);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_sync1, r_sync2, r_prev;
   logic [DIV_WIDTH-1:0]     r_div_cnt;
   logic [TW-1:0]            r_tick_cnt;
   logic [3:0]               r_bit_cnt;
   logic                     r_stop_cnt;
   logic [3:0]               r_nbits;
   logic [1:0]               r_par_mode;
   logic                     r_stop2;
   logic [MAX_DATA_BITS-1:0] r_shift;
   logic                     r_par_bit, r_par_err, r_frm_err, r_stop0_low;
   logic [MAX_DATA_BITS-1:0] r_word;
   logic                     r_valid, r_out_par_err, r_out_frm_err, r_out_brk;

   logic       w_rx, w_fall, w_div_run, w_tick, w_sample, w_done;
   logic       w_last_data, w_last_stop, w_par_en, w_par_xor, w_par_mis;
   logic       w_first_stop_low, w_brk;
   logic [3:0] w_nbits;

   assign w_rx      = r_sync2;
   assign w_fall    = r_prev & ~r_sync2;
   assign w_div_run = rx_en_i && (baud_div_i != '0);
   // >= rather than == so a divisor lowered below the running count still wraps promptly
   assign w_tick    = w_div_run && (r_div_cnt >= baud_div_i - 1'b1);
   assign w_sample  = w_tick && ((r_state == S_START) ? (r_tick_cnt == MID_START)
                                                      : (r_tick_cnt == MID_BIT));
   assign w_nbits   = (data_bits_i < 4'd5) ? 4'd5 :
                      (data_bits_i > MAX_BITS) ? MAX_BITS : data_bits_i;

   assign w_last_data      = (r_bit_cnt == r_nbits - 4'd1);
   assign w_last_stop      = !r_stop2 || r_stop_cnt;
   assign w_par_en         = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
   assign w_par_xor        = (^r_shift) ^ w_rx;
   assign w_par_mis        = (r_par_mode == 2'b10) ? ~w_par_xor : w_par_xor;
   assign w_first_stop_low = r_stop2 ? r_stop0_low : ~w_rx;
   assign w_brk            = (r_shift == '0) && !(w_par_en && r_par_bit) && w_first_stop_low;

   // two-flop synchronizer plus previous value for falling-edge detect; idles high
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx_data_i;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // oversample tick divider, parked at zero while disabled or divisor is zero
   always_ff @(posedge clk_i) begin
      if (reset_i || !w_div_run || w_tick) r_div_cnt <= '0;
      else                                 r_div_cnt <= r_div_cnt + 1'b1;
   end

   // ticks within the current bit; restarts at every sample point
   always_ff @(posedge clk_i) begin
      if (reset_i || r_state == S_IDLE || w_sample) r_tick_cnt <= '0;
      else if (w_tick)                                r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // next-state logic; losing the enable abandons any frame in progress
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      if (r_state != S_IDLE && !rx_en_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (rx_en_i && w_fall) w_state_nxt = S_START;
            S_START:    if (w_sample) w_state_nxt = w_rx ? S_IDLE : S_DATA;
            S_DATA:     if (w_sample && w_last_data) w_state_nxt = w_par_en ? S_PARITY : S_STOP;
            S_PARITY:   if (w_sample) w_state_nxt = S_STOP;
            S_STOP: begin
               if (w_sample && w_last_stop) begin
                  w_done      = 1'b1;
                  w_state_nxt = w_brk ? S_BRK_WAIT : S_IDLE;
               end
            end
            S_BRK_WAIT: if (w_rx) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
         endcase
      end
   end

   // frame capture: config latched at start, then data/parity/stop samples accumulated
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_nbits     <= 4'd8;
         r_par_mode  <= 2'b00;
         r_stop2     <= 1'b0;
         r_bit_cnt   <= '0;
         r_stop_cnt  <= 1'b0;
         r_shift     <= '0;
         r_par_bit   <= 1'b0;
         r_par_err   <= 1'b0;
         r_frm_err   <= 1'b0;
         r_stop0_low <= 1'b0;
      end else if (r_state == S_IDLE && w_state_nxt == S_START) begin
         r_nbits     <= w_nbits;
         r_par_mode  <= parity_mode_i;
         r_stop2     <= stop_bits_i;
         r_bit_cnt   <= '0;
         r_stop_cnt  <= 1'b0;
         r_shift     <= '0;
         r_par_bit   <= 1'b0;
         r_par_err   <= 1'b0;
         r_frm_err   <= 1'b0;
         r_stop0_low <= 1'b0;
      end else if (w_sample) begin
         case (r_state)
            S_DATA: begin
               for (int i = 0; i < MAX_DATA_BITS; i++)
                  if (4'(i) == r_bit_cnt) r_shift[i] <= w_rx;
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            S_PARITY: begin
               r_par_bit <= w_rx;
               r_par_err <= w_par_mis;
            end
            S_STOP: begin
               r_stop_cnt <= 1'b1;
               if (!w_rx) r_frm_err <= 1'b1;
               if (!r_stop_cnt) r_stop0_low <= ~w_rx;
            end
            default: ;
         endcase
      end
   end

   // output word and flags update together with the valid pulse and hold until the next one
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_word        <= '0;
         r_valid       <= 1'b0;
         r_out_par_err <= 1'b0;
         r_out_frm_err <= 1'b0;
         r_out_brk     <= 1'b0;
      end else begin
         r_valid <= w_done;
         if (w_done) begin
            r_word        <= r_shift;
            r_out_par_err <= r_par_err;
            r_out_frm_err <= r_frm_err | ~w_rx;
            r_out_brk     <= w_brk;
         end
      end
   end

   assign rx_word_o    = r_word;
   assign rx_valid_o   = r_valid;
   assign parity_err_o = r_out_par_err;
   assign frame_err_o  = r_out_frm_err;
   assign break_o      = r_out_brk;
   assign busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;
   localparam int BIT = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx_en = 1'b1;
   logic [15:0] baud_div = 16'd4;
   logic [3:0] data_bits = 4'd8;
   logic [1:0] parity_mode = 2'b00;
   logic       stop_bits = 1'b0;
   logic [8:0] rx_word_o;
   logic       rx_valid_o, parity_err_o, frame_err_o, break_o, busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   logic [8:0] mon_word [0:31];
   logic       mon_perr [0:31];
   logic       mon_ferr [0:31];
   logic       mon_brk  [0:31];
   int         mon_cyc  [0:31];

   uart_rx_cfg #(.MAX_DATA_BITS(9), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
      .clk_i(clk), .reset_i(reset), .rx_data_i(rx), .rx_en_i(rx_en),
      .baud_div_i(baud_div), .data_bits_i(data_bits), .parity_mode_i(parity_mode),
      .stop_bits_i(stop_bits), .rx_word_o(rx_word_o), .rx_valid_o(rx_valid_o),
      .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .break_o(break_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // free-running cycle count
   always @(posedge clk) cyc <= cyc + 1;

   // record every valid pulse with its accompanying word and flags
   always @(negedge clk) begin
      if (rx_valid_o === 1'b1) begin
         if (pulse_cnt < 32) begin
            mon_word[pulse_cnt] = rx_word_o;
            mon_perr[pulse_cnt] = parity_err_o;
            mon_ferr[pulse_cnt] = frame_err_o;
            mon_brk[pulse_cnt]  = break_o;
            mon_cyc[pulse_cnt]  = cyc;
         end
         pulse_cnt = pulse_cnt + 1;
      end
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                             input logic par, input int nstop, input logic stop_val);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(data[i]);
      if (has_par) drive_bit(par);
      for (int i = 0; i < nstop; i++) drive_bit(stop_val);
      rx = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid_o); end
      checks++; if (rx_word_o !== 9'h000) begin errors++; $display("FAIL reset_word got %h exp 000", rx_word_o); end
      checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err_o); end
      checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err_o); end
      checks++; if (break_o !== 1'b0) begin errors++; $display("FAIL reset_brk got %b exp 0", break_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
      reset = 1'b0;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic test_8n1;
      int n0, t0, lat;
      data_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
      n0 = pulse_cnt; t0 = cyc;
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      drive_bit(1'b1);
      lat = mon_cyc[n0] - t0;
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL a5_pulses got %0d exp %0d", pulse_cnt - n0, 1); end
      checks++; if (mon_word[n0] !== 9'h0A5) begin errors++; $display("FAIL a5_word got %h exp 0a5", mon_word[n0]); end
      checks++; if (mon_perr[n0] !== 1'b0 || mon_ferr[n0] !== 1'b0 || mon_brk[n0] !== 1'b0) begin
         errors++; $display("FAIL a5_flags got p%b f%b b%b exp 000", mon_perr[n0], mon_ferr[n0], mon_brk[n0]); end
      checks++; if (lat <= 0 || lat > 10 * BIT + 8) begin errors++; $display("FAIL a5_latency got %0d exp <= %0d", lat, 10 * BIT + 8); end
   endtask

   task automatic test_parity_7e2;
      int n0;
      data_bits = 4'd7; parity_mode = 2'b01; stop_bits = 1'b1;
      n0 = pulse_cnt;
      // 0x35 has four ones: even parity bit is 0
      send_frame(9'h035, 7, 1'b1, 1'b0, 2, 1'b1);
      drive_bit(1'b1);
      send_frame(9'h035, 7, 1'b1, 1'b1, 2, 1'b1);
      drive_bit(1'b1);
      checks++; if (pulse_cnt !== n0 + 2) begin errors++; $display("FAIL 7e2_pulses got %0d exp 2", pulse_cnt - n0); end
      checks++; if (mon_word[n0] !== 9'h035 || mon_perr[n0] !== 1'b0 || mon_ferr[n0] !== 1'b0) begin
         errors++; $display("FAIL 7e2_good got w%h p%b f%b exp w035 p0 f0", mon_word[n0], mon_perr[n0], mon_ferr[n0]); end
      checks++; if (mon_word[n0+1] !== 9'h035 || mon_perr[n0+1] !== 1'b1 || mon_ferr[n0+1] !== 1'b0) begin
         errors++; $display("FAIL 7e2_bad got w%h p%b f%b exp w035 p1 f0", mon_word[n0+1], mon_perr[n0+1], mon_ferr[n0+1]); end
   endtask

   task automatic test_frame_break;
      int n0;
      data_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
      n0 = pulse_cnt;
      send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
      drive_bit(1'b1);
      checks++; if (pulse_cnt !== n0 + 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", pulse_cnt - n0); end
      checks++; if (mon_word[n0] !== 9'h03C || mon_ferr[n0] !== 1'b1 || mon_brk[n0] !== 1'b0) begin
         errors++; $display("FAIL ferr_frame got w%h f%b b%b exp w03c f1 b0", mon_word[n0], mon_ferr[n0], mon_brk[n0]); end
      rx = 1'b0;
      repeat (12 * BIT) @(negedge clk);
      checks++; if (pulse_cnt !== n0 + 2) begin errors++; $display("FAIL brk_pulses got %0d exp 2", pulse_cnt - n0); end
      checks++; if (mon_word[n0+1] !== 9'h000 || mon_ferr[n0+1] !== 1'b1 || mon_brk[n0+1] !== 1'b1) begin
         errors++; $display("FAIL brk_frame got w%h f%b b%b exp w000 f1 b1", mon_word[n0+1], mon_ferr[n0+1], mon_brk[n0+1]); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL brk_busy_low got %b exp 1", busy_o); end
      rx = 1'b1;
      repeat (8) @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL brk_busy_high got %b exp 0", busy_o); end
      drive_bit(1'b1);
      send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
      drive_bit(1'b1);
      checks++; if (pulse_cnt !== n0 + 3 || mon_word[n0+2] !== 9'h05A || mon_ferr[n0+2] !== 1'b0 || mon_brk[n0+2] !== 1'b0) begin
         errors++; $display("FAIL after_brk got n%0d w%h f%b b%b exp n3 w05a f0 b0", pulse_cnt - n0, mon_word[n0+2], mon_ferr[n0+2], mon_brk[n0+2]); end
   endtask

   task automatic test_glitch;
      int n0;
      n0 = pulse_cnt;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      checks++; if (pulse_cnt !== n0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", pulse_cnt - n0); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy_o); end
      send_frame(9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
      drive_bit(1'b1);
      checks++; if (pulse_cnt !== n0 + 1 || mon_word[n0] !== 9'h081 || mon_ferr[n0] !== 1'b0) begin
         errors++; $display("FAIL glitch_next got n%0d w%h f%b exp n1 w081 f0", pulse_cnt - n0, mon_word[n0], mon_ferr[n0]); end
   endtask

   task automatic test_abort;
      int n0;
      n0 = pulse_cnt;
      drive_bit(1'b0);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b exp 1", busy_o); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (rx_word_o !== 9'h000 || parity_err_o !== 1'b0 || frame_err_o !== 1'b0 || break_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL abort_reset_out got w%h p%b f%b b%b y%b exp all 0", rx_word_o, parity_err_o, frame_err_o, break_o, busy_o); end
      repeat (9 * BIT) @(negedge clk);
      checks++; if (pulse_cnt !== n0) begin errors++; $display("FAIL abort_reset_pulses got %0d exp 0", pulse_cnt - n0); end
      drive_bit(1'b0);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      rx_en = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_en_busy got %b exp 0", busy_o); end
      repeat (9 * BIT) @(negedge clk);
      rx_en = 1'b1;
      repeat (BIT) @(negedge clk);
      checks++; if (pulse_cnt !== n0 || rx_word_o !== 9'h000 || frame_err_o !== 1'b0) begin
         errors++; $display("FAIL abort_en_out got n%0d w%h f%b exp n0 w000 f0", pulse_cnt - n0, rx_word_o, frame_err_o); end
   endtask

   task automatic test_back_to_back;
      int n0;
      data_bits = 4'd9; parity_mode = 2'b10; stop_bits = 1'b0;
      n0 = pulse_cnt;
      // 0x1F3 has seven ones: odd parity bit is 0; second frame uses a clamped length of 5
      fork
         begin
            send_frame(9'h1F3, 9, 1'b1, 1'b0, 1, 1'b1);
            send_frame(9'h015, 5, 1'b0, 1'b0, 1, 1'b1);
         end
         begin
            repeat (100) @(negedge clk);
            data_bits = 4'd3; parity_mode = 2'b00;
         end
      join
      drive_bit(1'b1);
      checks++; if (pulse_cnt !== n0 + 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulse_cnt - n0); end
      checks++; if (mon_word[n0] !== 9'h1F3 || mon_perr[n0] !== 1'b0 || mon_ferr[n0] !== 1'b0) begin
         errors++; $display("FAIL b2b_first got w%h p%b f%b exp w1f3 p0 f0", mon_word[n0], mon_perr[n0], mon_ferr[n0]); end
      checks++; if (mon_word[n0+1] !== 9'h015 || mon_perr[n0+1] !== 1'b0 || mon_ferr[n0+1] !== 1'b0) begin
         errors++; $display("FAIL b2b_second got w%h p%b f%b exp w015 p0 f0", mon_word[n0+1], mon_perr[n0+1], mon_ferr[n0+1]); end
   endtask

   initial begin
      test_reset;
      test_8n1;
      test_parity_7e2;
      test_frame_break;
      test_glitch;
      test_abort;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
